// File: rtl/controle_contagem_pkg.sv
// rtl/controle_contagem_pkg.sv - shared types and constants for the countdown sequencer
package pkg_contagem;

    typedef enum logic [2:0] {
        IDLE,
        PRONTO,
        RUN,
        PAUSA,
        FIM
    } estado_t;

    typedef logic [6:0] valor_t;

    localparam valor_t MAX_VAL = 7'd99;
    localparam valor_t X_BLANK = 7'd0;

    function automatic valor_t sat_valor(input valor_t v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

endpackage

// File: rtl/controle_contagem_if.sv
// rtl/controle_contagem_if.sv - button pulses in, decoder value/enable out
interface controle_contagem_if;
    import pkg_contagem::*;

    logic   load;
    valor_t valor;
    logic   start;
    logic   pause;
    logic   cancel;
    valor_t X;
    logic   EN;
    logic   fim;

    modport master (
        output load, valor, start, pause, cancel,
        input  X, EN, fim
    );

    modport slave (
        input  load, valor, start, pause, cancel,
        output X, EN, fim
    );

endinterface

// File: rtl/controle_contagem_divisor_tick.sv
// rtl/controle_contagem_divisor_tick.sv - enabled modulo-DIV counter with one-cycle tick on wrap
module divisor_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Tick is combinational from the held count so the owner acts on the wrap edge itself.
    assign tick = en && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/controle_contagem.sv
// rtl/controle_contagem.sv - countdown FSM with pause/resume/cancel and blink-at-zero
module controle_contagem
    import pkg_contagem::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 12_500_000,
    parameter int BLINK_N   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    controle_contagem_if.slave   bus
);

    localparam int HW = $clog2(BLINK_N + 1);
    localparam logic [HW-1:0] HLAST = HW'(BLINK_N - 1);

    estado_t       state_q, state_d;
    valor_t        x_q, x_d;
    logic          en_q, en_d;
    logic          fim_q, fim_d;
    logic [HW-1:0] half_q, half_d;

    valor_t valor_sat;
    logic   tick_cnt, tick_blink;
    logic   clr_cnt, clr_blink;
    logic   run_en, blink_en;

    assign valor_sat = sat_valor(bus.valor);
    assign run_en    = (state_q == RUN);
    assign blink_en  = (state_q == FIM);

    // Prescaler survives only across RUN<->PAUSA so resume continues the partial unit.
    assign clr_cnt   = bus.cancel
                     || ((state_q == PAUSA) && bus.load)
                     || !((state_q == RUN) || (state_q == PAUSA));
    assign clr_blink = bus.cancel || bus.load || (state_q != FIM);

    divisor_tick #(.DIV(TICK_DIV)) u_div_conta (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .en    (run_en),
        .tick  (tick_cnt)
    );

    divisor_tick #(.DIV(BLINK_DIV)) u_div_pisca (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_blink),
        .en    (blink_en),
        .tick  (tick_blink)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        en_d    = en_q;
        fim_d   = 1'b0;
        half_d  = half_q;

        if (bus.cancel) begin
            state_d = IDLE;
            x_d     = X_BLANK;
            en_d    = 1'b0;
            half_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        state_d = PRONTO;
                        x_d     = valor_sat;
                        en_d    = 1'b1;
                    end
                end
                PRONTO: begin
                    if (bus.load) begin
                        x_d = valor_sat;
                    end else if (bus.start && (x_q != X_BLANK)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // Terminal decrement beats a coincident pause.
                    if (tick_cnt && (x_q == 7'd1)) begin
                        state_d = FIM;
                        x_d     = X_BLANK;
                        fim_d   = 1'b1;
                        en_d    = 1'b1;
                        half_d  = '0;
                    end else begin
                        if (tick_cnt) begin
                            x_d = x_q - 7'd1;
                        end
                        if (bus.pause) begin
                            state_d = PAUSA;
                        end
                    end
                end
                PAUSA: begin
                    if (bus.load) begin
                        state_d = PRONTO;
                        x_d     = valor_sat;
                    end else if (bus.start) begin
                        state_d = RUN;
                    end
                end
                FIM: begin
                    if (bus.load) begin
                        state_d = PRONTO;
                        x_d     = valor_sat;
                        en_d    = 1'b1;
                        half_d  = '0;
                    end else if (tick_blink) begin
                        if (half_q == HLAST) begin
                            state_d = IDLE;
                            en_d    = 1'b0;
                            half_d  = '0;
                        end else begin
                            en_d   = !en_q;
                            half_d = half_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    x_d     = X_BLANK;
                    en_d    = 1'b0;
                    half_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= X_BLANK;
            en_q    <= 1'b0;
            fim_q   <= 1'b0;
            half_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            en_q    <= en_d;
            fim_q   <= fim_d;
            half_q  <= half_d;
        end
    end

    assign bus.X   = x_q;
    assign bus.EN  = en_q;
    assign bus.fim = fim_q;

endmodule

// File: doc/controle_contagem.md
# controle_contagem

Countdown sequencer for the two-digit seven-segment decoder. It holds the 7-bit value X (0–99) and the display enable EN that feed the decoder. It loads a preset, counts down one unit per prescaled tick, supports pause, resume and cancel, and blinks the display at zero before blanking. It sits between the board buttons/switches (already synchronised and single-cycle pulsed) and the decoder.

## Interface
- TICK_DIV, 50_000_000: clock cycles per countdown unit; legal range ≥2.
- BLINK_DIV, 12_500_000: clock cycles per blink half-period in FIM; legal range ≥1.
- BLINK_N, 6: number of blink half-periods in FIM; must be even and ≥2.
- clk  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- load  in  1  one-cycle pulse; load `valor`.
- valor  in  7  preset; values >99 saturate to 99.
- start  in  1  one-cycle pulse; start or resume.
- pause  in  1  one-cycle pulse; freeze the count.
- cancel  in  1  one-cycle pulse; abort to IDLE.
- X  out  7  count value to the decoder (registered).
- EN  out  1  decoder enable (registered).
- fim  out  1  one-cycle pulse when the count reaches 0.

## Operation
- States: IDLE, PRONTO, RUN, PAUSA, FIM.
- Reset values: state=IDLE, X=0, EN=0, fim=0, prescaler=0, blink counters=0.
- Priority when pulses coincide: cancel > load > start > pause. Only the highest-priority applicable pulse acts.
- cancel, from any state: go to IDLE, X=0, EN=0, prescaler cleared.
- IDLE:
  - EN=0.
  - load → PRONTO, X=sat(valor).
  - start and pause are ignored.
- PRONTO:
  - EN=1.
  - load reloads X.
  - start with X≠0 → RUN, prescaler=0.
  - start with X=0 is ignored.
- RUN:
  - EN=1.
  - The prescaler counts 0..TICK_DIV-1. On reaching TICK_DIV-1 it wraps to 0 and X decrements.
  - When a decrement takes X from 1 to 0: go to FIM and assert fim on that same edge.
  - pause → PAUSA; the prescaler value is held.
  - load is ignored in RUN.
- PAUSA:
  - EN=1; X and prescaler are frozen.
  - start → RUN, resuming from the held prescaler value.
  - load → PRONTO, X=sat(valor), prescaler=0.
- FIM:
  - X=0.
  - EN starts at 1 and toggles every BLINK_DIV cycles.
  - After BLINK_N half-periods → IDLE with EN=0.
  - load → PRONTO; start and pause are ignored.
- Saturation: X=min(valor,99), computed combinationally on load. X never underflows and never exceeds 99.

## Timing
- All outputs are registered. Input pulses are sampled on edge k; the effect is visible after edge k.
- Load latency: 1 cycle.
- First decrement occurs TICK_DIV cycles after the edge that sampled start from PRONTO.
- Each further decrement follows the previous one by exactly TICK_DIV cycles.
- Pause/resume: the total cycles of RUN per decrement is TICK_DIV, independent of pause placement.
- fim is high for exactly 1 cycle, on the cycle X first reads 0.
- FIM duration: BLINK_N×BLINK_DIV cycles. On the following edge the state is IDLE.
- pause on the same edge as the terminal decrement: the decrement wins, state goes to FIM, and pause is dropped.
- Reset asserted mid-count: all outputs go to reset values immediately (asynchronously). Counting does not resume after reset release.

## Structure
- Shared package `pkg_contagem`:
  - state enum (IDLE, PRONTO, RUN, PAUSA, FIM)
  - constant MAX_VAL=99
  - blank pattern constant
- Sub-module `divisor_tick`:
  - parameter DIV; inputs clk, rst_n, clr, en; output tick (1 cycle every DIV enabled cycles).
  - Instantiated twice: once for the countdown prescaler, once for the blink half-period.
- The FSM and X register live in the top module.

## Test plan
Bench parameters: TICK_DIV=4, BLINK_DIV=2, BLINK_N=4.
- Reset check: rst_n low mid-RUN with X=5 → X=0, EN=0, fim=0 immediately; state stays IDLE after release.
- Load and count: load valor=3, then start → X=3 for 4 cycles, then 2, 1, 0. fim pulses once with X=0. EN reads 1,1,0,0,1,1,0,0, then IDLE with EN=0.
- Saturation and X=0 start:
  - load valor=120 → X=99.
  - load valor=0, then start → remains PRONTO, X=0, no fim.
- Pause/resume: start with X=2, pause 2 cycles after start, wait 10 cycles, start → first decrement 2 cycles after resume (X=1).
- Simultaneous pulses:
  - load=1 and cancel=1 on the same cycle in PAUSA → IDLE, X=0.
  - start=1 and pause=1 in PRONTO → RUN.
  - pause on the terminal-decrement edge → FIM, fim=1.
- Reload: load valor=7 during FIM → PRONTO, X=7, EN=1, blink aborted.
